sr_latch_nand: RTL and testbench

SR_LATCH_NAND -- requirements
Module: sr_latch_nand

---
 rtl/sr_latch_pkg.sv | 28 ++
 rtl/sr_input_sync.sv | 31 +++
 rtl/sr_latch_nand.sv | 97 +++++++++
 tb/tb_sr_latch_nand.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types for the clocked NAND SR latch: state encoding and exit-policy codes.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        RST_ST = 2'b00,
        SET_ST = 2'b01,
        INV_ST = 2'b10
    } sr_state_e;

    localparam int EXIT_RESTORE   = 0;
    localparam int EXIT_FORCE_RST = 1;

    localparam int SYNC_MAX = 3;

    // Output pattern {Q, Qn} for a given state.
    function automatic logic [1:0] state_outputs(input sr_state_e st);
        logic [1:0] qq;
        qq = 2'b01;
        case (st)
            RST_ST:  qq = 2'b01;
            SET_ST:  qq = 2'b10;
            INV_ST:  qq = 2'b11;
            default: qq = 2'b01;
        endcase
        return qq;
    endfunction

endpackage

// File: rtl/sr_input_sync.sv
// Reset-to-idle synchronizer chain for one active-low request input; depth 0 is a wire.
module sr_input_sync #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    if (DEPTH == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_chain
        logic [DEPTH-1:0] sync_q;

        // Reset to 1: an active-low request line idles high.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '1;
            end else begin
                sync_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign q_o = sync_q[DEPTH-1];
    end

endmodule

// File: rtl/sr_latch_nand.sv
// Clocked model of a cross-coupled NAND SR latch with optional input synchronizers,
// a remembered last valid state for leaving the S=R=0 condition, and a sticky invalid flag.
module sr_latch_nand
    import sr_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int EXIT_POLICY = EXIT_RESTORE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic S,
    input  logic R,
    input  logic clr_seen,
    output logic Q,
    output logic Qn,
    output logic invalid,
    output logic invalid_seen
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("sr_latch_nand: SYNC_STAGES=%0d out of range 0..3", SYNC_STAGES);
    end
    if (EXIT_POLICY != EXIT_RESTORE && EXIT_POLICY != EXIT_FORCE_RST) begin : g_bad_exit
        $error("sr_latch_nand: EXIT_POLICY=%0d out of range 0..1", EXIT_POLICY);
    end

    logic s_sync, r_sync;

    sr_input_sync #(.DEPTH(SYNC_STAGES)) u_sync_s (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (S),
        .q_o   (s_sync)
    );

    sr_input_sync #(.DEPTH(SYNC_STAGES)) u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (R),
        .q_o   (r_sync)
    );

    sr_state_e  state_q, state_d;
    sr_state_e  last_q, last_d;
    logic       q_q, qn_q, inv_q, seen_q;
    logic       seen_d;
    logic [1:0] qq_d;
    logic       enter_inv;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case ({s_sync, r_sync})
            2'b01: state_d = SET_ST;
            2'b10: state_d = RST_ST;
            2'b00: state_d = INV_ST;
            2'b11: begin
                if (state_q == INV_ST) begin
                    state_d = (EXIT_POLICY == EXIT_FORCE_RST) ? RST_ST : last_q;
                end
            end
            default: state_d = state_q;
        endcase
        if (state_d != INV_ST) begin
            last_d = state_d;
        end
    end

    assign enter_inv = (state_d == INV_ST) && (state_q != INV_ST);
    // Set wins over a coincident clear.
    assign seen_d    = enter_inv ? 1'b1 : (clr_seen ? 1'b0 : seen_q);
    assign qq_d      = state_outputs(state_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_ST;
            last_q  <= RST_ST;
            q_q     <= 1'b0;
            qn_q    <= 1'b1;
            inv_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            q_q     <= qq_d[1];
            qn_q    <= qq_d[0];
            inv_q   <= (state_d == INV_ST);
            seen_q  <= seen_d;
        end
    end

    assign Q            = q_q;
    assign Qn           = qn_q;
    assign invalid      = inv_q;
    assign invalid_seen = seen_q;

endmodule

// File: tb/tb_sr_latch_nand.sv
// Drives three latch configurations from shared inputs and compares each against a
// rule-level reference model (directed scenarios followed by random S/R/clr traffic).
module tb_sr_latch_nand;

    logic clk = 1'b0;
    logic rst_n, S, R, clr_seen;
    logic [2:0] q, qn, inv, seen;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    sr_latch_nand #(.SYNC_STAGES(0), .EXIT_POLICY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clr_seen(clr_seen),
        .Q(q[0]), .Qn(qn[0]), .invalid(inv[0]), .invalid_seen(seen[0]));
    sr_latch_nand #(.SYNC_STAGES(0), .EXIT_POLICY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clr_seen(clr_seen),
        .Q(q[1]), .Qn(qn[1]), .invalid(inv[1]), .invalid_seen(seen[1]));
    sr_latch_nand #(.SYNC_STAGES(2), .EXIT_POLICY(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clr_seen(clr_seen),
        .Q(q[2]), .Qn(qn[2]), .invalid(inv[2]), .invalid_seen(seen[2]));

    int stages [3] = '{0, 0, 2};
    int policy [3] = '{0, 1, 0};

    // Reference: raw input history plus per-instance output/memory bits.
    bit hs [4];
    bit hr [4];
    bit mq [3], mqn [3], mlast_set [3], mseen [3];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            hs[i] = 1'b1;
            hr[i] = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            mq[k] = 1'b0; mqn[k] = 1'b1; mlast_set[k] = 1'b0; mseen[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge(bit s, bit r, bit clr);
        for (int i = 3; i > 0; i--) begin
            hs[i] = hs[i-1];
            hr[i] = hr[i-1];
        end
        hs[0] = s;
        hr[0] = r;
        for (int k = 0; k < 3; k++) begin
            bit ss, rr, was_inv, nq, nqn;
            ss = hs[stages[k]];
            rr = hr[stages[k]];
            was_inv = mq[k] && mqn[k];
            nq = mq[k];
            nqn = mqn[k];
            if (!ss && rr) begin
                nq = 1; nqn = 0;
            end else if (ss && !rr) begin
                nq = 0; nqn = 1;
            end else if (!ss && !rr) begin
                nq = 1; nqn = 1;
            end else if (was_inv) begin
                nq = (policy[k] == 1) ? 1'b0 : mlast_set[k];
                nqn = ~nq;
            end
            if (!(nq && nqn)) mlast_set[k] = nq;
            if (nq && nqn && !was_inv) mseen[k] = 1'b1;
            else if (clr) mseen[k] = 1'b0;
            mq[k] = nq;
            mqn[k] = nqn;
        end
    endfunction

    task automatic chk(input string tag, input int k);
        logic [3:0] obs, exp;
        obs = {q[k], qn[k], inv[k], seen[k]};
        exp = {mq[k], mqn[k], mq[k] & mqn[k], mseen[k]};
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s dut%0d {Q,Qn,inv,seen} observed=%b expected=%b", tag, k, obs, exp);
    endtask

    task automatic chk_all(input string tag);
        for (int k = 0; k < 3; k++) chk(tag, k);
    endtask

    task automatic cyc(input bit s, input bit r, input bit clr, input string tag);
        @(negedge clk);
        S = s; R = r; clr_seen = clr;
        @(posedge clk);
        model_edge(s, r, clr);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; S = 1'b1; R = 1'b1; clr_seen = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // set then hold
        cyc(0, 1, 0, "set");
        cyc(1, 1, 0, "hold_set");
        cyc(1, 1, 0, "hold_set2");
        cyc(1, 1, 0, "sync2_set_lands");
        // reset then invalid
        cyc(1, 0, 0, "reset_req");
        cyc(0, 0, 0, "inv_enter");
        cyc(1, 1, 0, "inv_exit_rst");
        cyc(1, 1, 0, "settle");
        cyc(1, 1, 0, "settle2");
        // set, invalid, exit: restore vs forced reset
        cyc(0, 1, 0, "exit_seq_set");
        cyc(0, 0, 0, "exit_seq_inv");
        cyc(1, 1, 0, "exit_seq_exit");
        cyc(1, 1, 0, "exit_seq_hold");
        cyc(1, 1, 0, "exit_seq_hold2");
        // invalid held, clr during stay, then clr coinciding with new entry
        cyc(0, 0, 0, "inv_hold1");
        cyc(0, 0, 0, "inv_hold2");
        cyc(0, 0, 1, "inv_hold_clr");
        cyc(1, 1, 0, "inv_leave");
        cyc(0, 0, 1, "clr_vs_entry");
        cyc(1, 1, 0, "after_entry");
        cyc(1, 1, 1, "clr_no_entry");
        cyc(1, 1, 1, "clr_no_entry2");
        cyc(1, 1, 0, "idle");

        // async reset while invalid, between edges
        cyc(0, 0, 0, "pre_rst_inv");
        cyc(0, 0, 0, "pre_rst_inv2");
        cyc(0, 0, 0, "pre_rst_inv3");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_reset");
        @(negedge clk);
        S = 1'b1; R = 1'b1;
        rst_n = 1'b1;

        // exact sync latency: set request for one cycle, released after
        cyc(0, 1, 0, "lat_edge0");
        cyc(1, 1, 0, "lat_edge1");
        cyc(1, 1, 0, "lat_edge2");
        cyc(1, 1, 0, "lat_edge3");

        for (int i = 0; i < 300; i++) begin
            bit s, r, c;
            s = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 5) == 0);
            cyc(s, r, c, "random");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
